// File: rtl/fft_deserializer.sv
// fft_deserializer: packs 32-sample frames into 8-row x 4-lane bursts via a ping-pong buffer; FFT_DESER_SOF_EN adds the i_sof resync port
module fft_deserializer #(
  parameter int NB_DATA = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic [2*NB_DATA-1:0] i_din,
`ifdef FFT_DESER_SOF_EN
  input  logic                 i_sof,
`endif
  output logic [2*NB_DATA-1:0] o_dout_ch0,
  output logic [2*NB_DATA-1:0] o_dout_ch1,
  output logic [2*NB_DATA-1:0] o_dout_ch2,
  output logic [2*NB_DATA-1:0] o_dout_ch3,
  output logic                 o_valid
);
  localparam logic [0:0] IDLE = 1'b0, BURST = 1'b1;
  logic [2*NB_DATA-1:0] mem [64];
  logic [2*NB_DATA-1:0] dout_q [4], dout_d [4];
  logic [4:0] k_q, k_d, wr_k;
  logic [3:0] row_q, row_d;
  logic [2:0] rd_row;
  logic [0:0] state_q, state_d;
  logic wb_q, wb_d, fr_q, fr_d, frb_q, frb_d, rb_q, rb_d, valid_q, valid_d;
  logic acc, sof, ld, rbank;
`ifdef FFT_DESER_SOF_EN
  assign sof = i_sof;
`else
  assign sof = 1'b0;
`endif
  always_comb begin
    acc = i_valid && i_enable;
    wr_k = sof ? 5'd0 : k_q;
    k_d = acc ? wr_k + 5'd1 : k_q;
    fr_d = acc && !sof && k_q == 5'd31;
    wb_d = wb_q ^ fr_d;
    frb_d = wb_q;
    ld = state_q == IDLE ? fr_q : row_q != 4'd8;
    rbank = state_q == IDLE ? frb_q : rb_q;
    rd_row = state_q == IDLE ? 3'd0 : row_q[2:0];
    rb_d = rbank;
    row_d = state_q == IDLE ? 4'd1 : row_q + 4'd1;
    state_d = ld ? BURST : IDLE;
    valid_d = ld;
    for (int c = 0; c < 4; c++) dout_d[c] = ld ? mem[{rbank, rd_row, 2'(c)}] : '0;
  end
  // buffer contents are never reset; only control and output state is
  always_ff @(posedge i_clk)
    if (acc) mem[{wb_q, wr_k}] <= i_din;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      k_q <= '0;
      wb_q <= 1'b0;
      fr_q <= 1'b0;
      frb_q <= 1'b0;
      rb_q <= 1'b0;
      row_q <= '0;
      state_q <= IDLE;
      valid_q <= 1'b0;
      dout_q <= '{default: '0};
    end else begin
      k_q <= k_d;
      wb_q <= wb_d;
      fr_q <= fr_d;
      frb_q <= frb_d;
      rb_q <= rb_d;
      row_q <= row_d;
      state_q <= state_d;
      valid_q <= valid_d;
      dout_q <= dout_d;
    end
  assign o_dout_ch0 = dout_q[0];
  assign o_dout_ch1 = dout_q[1];
  assign o_dout_ch2 = dout_q[2];
  assign o_dout_ch3 = dout_q[3];
  assign o_valid = valid_q;
endmodule

// File: doc/fft_deserializer.md
# fft_deserializer

Serial-to-parallel front end for the 4-lane FFT datapath; the inverse of the FFT output serializer. Accepts one complex sample per valid cycle, packs each group of 32 consecutive samples (one frame) into 8 rows of 4 lanes, and emits the frame as an uninterrupted 8-cycle burst of 4-wide vectors. A ping-pong buffer lets the next frame fill while the previous one is bursting out.

## Interface

- NB_DATA, 12, bits per real/imag component; complex word is {re, im}, 2*NB_DATA bits
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_enable  in  1  input gate; sample accepted only when i_valid && i_enable
- i_valid  in  1  input sample valid
- i_din  in  2*NB_DATA  serial complex sample
- i_sof  in  1  start-of-frame marker (present only with FFT_DESER_SOF_EN)
- o_dout_ch0..o_dout_ch3  out  2*NB_DATA each  lane outputs of current row
- o_valid  out  1  row valid; high for exactly 8 consecutive cycles per frame

## Operation

- Accept = i_valid && i_enable. Write counter k (5-bit, 0..31) indexes the write bank: sample k goes to row k[4:2], lane k[1:0]. Lane index fastest, row next.
- k increments on each accept; holds otherwise (gaps in i_valid pause, do not restart, the frame).
- On the accept with k==31: k wraps to 0, write bank toggles, a one-cycle frame_ready pulse is registered carrying the completed bank index.
- Read FSM, two states:
  - IDLE: outputs hold 0, o_valid=0. On frame_ready, load row 0 of the completed bank into output registers, o_valid=1, rd_row=1, go BURST.
  - BURST: each cycle load row rd_row, rd_row++. After row 7 is loaded, the next edge clears o_valid and outputs to 0 and returns to IDLE.
- Overlap is impossible: a burst lasts 8 cycles, a frame fill ≥32 cycles. No overflow flag.
- i_enable only gates input; an in-progress burst always completes.
- Buffer memory is not reset. Counters, bank select, FSM, and output registers are.
- Reset (async, any time): o_valid=0, all o_dout_ch*=0, k=0, write bank=0, FSM=IDLE, frame_ready=0. A partial frame or in-flight burst is discarded.

## Timing

- Reset values: o_valid=0, o_dout_ch0..3=0.
- Sample 31 accepted at edge E. frame_ready is high during E..E+1. Row 0 is registered at E+1, rows 1..7 at E+2..E+8, and o_valid falls at E+9.
- Latency: first row visible 2 cycles after the cycle presenting sample 31.
- Outputs are fully registered; no combinational path from inputs to outputs.
- Simultaneous accept of sample 31 of frame N+1 and a BURST state: cannot occur (see above).
- Simultaneous accept and burst on the other bank: independent; no stall.

## Configuration

- FFT_DESER_SOF_EN defined: port i_sof exists. An accept with i_sof=1 writes the sample as k=0 of the current write bank and sets k=1. The previous partial frame is discarded, the bank is not marked ready, and no burst occurs for it. i_sof on a cycle where k would already be 0 is a no-op resync. i_sof without accept is ignored.
- Not defined: no i_sof port. Frame alignment is purely by count from reset.

## Test plan

- 32 back-to-back accepts with re=k, im=0 → 2 cycles after sample 31, o_valid high 8 cycles; row r lane c has re=4r+c. o_valid=0 and outputs=0 otherwise.
- 64 back-to-back accepts (values k=0..63) → two bursts with row-0 starts 32 cycles apart. The second burst carries values 32..63, proving ping-pong bank toggling.
- i_valid every other cycle for 64 cycles (32 accepts) → identical burst contents. The burst starts 2 cycles after the 32nd accept.
- i_enable low for 5 cycles mid-frame with i_valid high → those 5 samples are dropped. The burst appears after 32 enabled accepts, and contents skip the gated values.
- Assert i_rst during burst row 3 → o_valid and all lanes 0 in the same cycle. A following 32-sample frame bursts correctly from k=0.
- FFT_DESER_SOF_EN: 10 accepts, then an accept with i_sof=1 and value 100, then 31 more accepts (101..131) → exactly one burst, with row 0 = {100,101,102,103}.
